// File: rtl/aes_pkg.sv
// Shared AES constants, state encoding and helpers for the inverse key scheduler.
package aes_pkg;

    localparam int NUM_ROUNDS = 10;
    localparam int KEY_W      = 128;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_SERVE  = 2'd2,
        ST_HOLD   = 2'd3
    } ks_state_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Round constant for rounds 1..10; anything else yields zero.
    function automatic logic [7:0] rcon_at(input logic [3:0] r);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 1; i <= NUM_ROUNDS; i++) begin
            v = (r == 4'(i)) ? RCON[i] : v;
        end
        return v;
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: four parallel S-box lookups on a 32-bit word (no rotation).
module aes_subword
    import aes_pkg::*;
(
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    assign word_out = {SBOX[word_in[31:24]], SBOX[word_in[23:16]],
                       SBOX[word_in[15:8]],  SBOX[word_in[7:0]]};

endmodule

// File: rtl/inv_key_sched.sv
// Inverse AES-128 key scheduler: expands to the round-10 key, then serves keys 10..0.
// Option INV_KS_K10_CACHE_EN: keep the round-10 key so restart skips re-expansion.
module inv_key_sched
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic             restart,
    output logic [KEY_W-1:0] rk_out,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [3:0]       round_idx,
    output logic             rk_last,
    output logic             done
);

    ks_state_t        state;
    logic [KEY_W-1:0] work_r;
    logic [KEY_W-1:0] stored_r;
    logic [3:0]       cnt_r;

    logic [31:0]      w0_s, w1_s, w2_s, w3_s;
    logic [31:0]      sub_in_s, sub_out_s;
    logic [7:0]       rcon_s;
    logic [31:0]      f0_s, f1_s, f2_s, f3_s;
    logic [31:0]      p0_s;
    logic [KEY_W-1:0] fwd_key_s, inv_key_s;

    assign rk_out = work_r;
    assign {w0_s, w1_s, w2_s, w3_s} = work_r;

    aes_subword u_subword (
        .word_in  (sub_in_s),
        .word_out (sub_out_s)
    );

    // One S-box path: the inverse step needs SubWord of the recovered previous last word (w3^w2).
    always_comb begin
        sub_in_s = rot_word(w3_s);
        rcon_s   = rcon_at(cnt_r + 4'd1);
        if (state == ST_SERVE) begin
            sub_in_s = rot_word(w3_s ^ w2_s);
            rcon_s   = rcon_at(round_idx);
        end else begin
            sub_in_s = rot_word(w3_s);
            rcon_s   = rcon_at(cnt_r + 4'd1);
        end
    end

    // Forward and inverse one-round key transforms of the working register.
    always_comb begin
        f0_s      = w0_s ^ sub_out_s ^ {rcon_s, 24'h000000};
        f1_s      = w1_s ^ f0_s;
        f2_s      = w2_s ^ f1_s;
        f3_s      = w3_s ^ f2_s;
        fwd_key_s = {f0_s, f1_s, f2_s, f3_s};
        p0_s      = w0_s ^ sub_out_s ^ {rcon_s, 24'h000000};
        inv_key_s = {p0_s, w1_s ^ w0_s, w2_s ^ w1_s, w3_s ^ w2_s};
    end

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            work_r    <= '0;
            stored_r  <= '0;
            cnt_r     <= 4'd0;
            rk_valid  <= 1'b0;
            round_idx <= 4'd0;
            rk_last   <= 1'b0;
            done      <= 1'b0;
            key_ready <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_HOLD: begin
                    if (key_valid) begin
                        work_r    <= key_in;
                        cnt_r     <= 4'd0;
                        state     <= ST_EXPAND;
                        key_ready <= 1'b0;
`ifndef INV_KS_K10_CACHE_EN
                        stored_r  <= key_in;
`endif
                    end else if (state == ST_HOLD && restart) begin
                        work_r    <= stored_r;
                        key_ready <= 1'b0;
`ifdef INV_KS_K10_CACHE_EN
                        state     <= ST_SERVE;
                        rk_valid  <= 1'b1;
                        round_idx <= 4'(NUM_ROUNDS);
`else
                        cnt_r     <= 4'd0;
                        state     <= ST_EXPAND;
`endif
                    end
                end
                ST_EXPAND: begin
                    work_r <= fwd_key_s;
                    if (cnt_r == 4'(NUM_ROUNDS - 1)) begin
                        state     <= ST_SERVE;
                        rk_valid  <= 1'b1;
                        round_idx <= 4'(NUM_ROUNDS);
                        rk_last   <= 1'b0;
`ifdef INV_KS_K10_CACHE_EN
                        stored_r  <= fwd_key_s;
`endif
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                ST_SERVE: begin
                    if (rk_ready) begin
                        if (round_idx == 4'd0) begin
                            state     <= ST_HOLD;
                            rk_valid  <= 1'b0;
                            rk_last   <= 1'b0;
                            done      <= 1'b1;
                            key_ready <= 1'b1;
                        end else begin
                            work_r    <= inv_key_s;
                            round_idx <= round_idx - 4'd1;
                            rk_last   <= (round_idx == 4'd1);
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    rk_valid  <= 1'b0;
                    key_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
